// File: rtl/input_conditioner.sv
// Button front end for the snake game: synchronises and debounces the raw buttons
// on vsync rising edges and keeps a 2-deep queue of requested turn directions.
module input_conditioner #(
  parameter int         DEBOUNCE_FRAMES = 2,
  parameter logic [1:0] RESET_DIR       = 2'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_restart,
  input  logic       i_vsync,
  input  logic       i_tick_done,
  output logic       o_up,
  output logic       o_down,
  output logic       o_right,
  output logic       o_restart,
  output logic       o_left,
  output logic [1:0] o_dir,
  output logic       o_restart_pulse,
  output logic [1:0] o_queue_level
);

  localparam logic [2:0] CNT_LAST = 3'(DEBOUNCE_FRAMES - 1);

  // Button bit order: 0=up, 1=down, 2=left, 3=right, 4=restart.
  logic [4:0] w_raw;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_stable;
  logic [4:0] r_stable_d;
  logic [2:0] r_cnt [5];
  logic       r_prev_vsync;
  logic       w_vs_rise;
  logic [4:0] w_rise;

  logic [1:0] r_dir;
  logic [1:0] r_q0;
  logic [1:0] r_q1;
  logic [1:0] r_level;
  logic       r_restart_pulse;

  logic       w_evt_valid;
  logic [1:0] w_evt_dir;
  logic       w_pop;
  logic [1:0] w_dir_pp;
  logic [1:0] w_q0_pp;
  logic [1:0] w_lvl_pp;
  logic [1:0] w_ref;
  logic       w_push;

  assign w_raw     = {i_btn_restart, i_btn_right, i_btn_left, i_btn_down, i_btn_up};
  assign w_vs_rise = i_vsync & ~r_prev_vsync;
  assign w_rise    = r_stable & ~r_stable_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1      <= 5'd0;
      r_sync2      <= 5'd0;
      r_stable     <= 5'd0;
      r_stable_d   <= 5'd0;
      r_prev_vsync <= 1'b0;
      for (int b = 0; b < 5; b++) begin
        r_cnt[b] <= 3'd0;
      end
    end else begin
      r_sync1      <= w_raw;
      r_sync2      <= r_sync1;
      r_stable_d   <= r_stable;
      r_prev_vsync <= i_vsync;
      // A level only flips after DEBOUNCE_FRAMES consecutive differing frame samples.
      if (w_vs_rise) begin
        for (int b = 0; b < 5; b++) begin
          if (r_sync2[b] == r_stable[b]) begin
            r_cnt[b] <= 3'd0;
          end else if (r_cnt[b] == CNT_LAST) begin
            r_stable[b] <= r_sync2[b];
            r_cnt[b]    <= 3'd0;
          end else begin
            r_cnt[b] <= r_cnt[b] + 3'd1;
          end
        end
      end
    end
  end

  always_comb begin
    w_evt_valid = 1'b1;
    w_evt_dir   = 2'd0;
    if (w_rise[0]) begin
      w_evt_dir = 2'd0;
    end else if (w_rise[1]) begin
      w_evt_dir = 2'd2;
    end else if (w_rise[2]) begin
      w_evt_dir = 2'd3;
    end else if (w_rise[3]) begin
      w_evt_dir = 2'd1;
    end else begin
      w_evt_valid = 1'b0;
    end
  end

  // Pop is applied first; the push is then judged against the post-pop tail.
  always_comb begin
    w_pop    = i_tick_done && (r_level != 2'd0);
    w_dir_pp = w_pop ? r_q0 : r_dir;
    w_q0_pp  = w_pop ? r_q1 : r_q0;
    w_lvl_pp = r_level - {1'b0, w_pop};
    case (w_lvl_pp)
      2'd0:    w_ref = w_dir_pp;
      2'd1:    w_ref = w_q0_pp;
      default: w_ref = r_q1;
    endcase
    w_push = w_evt_valid && (w_evt_dir != w_ref) && (w_evt_dir != (w_ref ^ 2'b10)) &&
             (w_lvl_pp != 2'd2) && !r_stable[4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir           <= RESET_DIR;
      r_q0            <= 2'd0;
      r_q1            <= 2'd0;
      r_level         <= 2'd0;
      r_restart_pulse <= 1'b0;
    end else begin
      r_restart_pulse <= w_rise[4];
      if (w_rise[4]) begin
        r_dir   <= RESET_DIR;
        r_level <= 2'd0;
      end else begin
        r_dir   <= w_dir_pp;
        r_q0    <= w_q0_pp;
        r_level <= w_lvl_pp + {1'b0, w_push};
        if (w_push) begin
          if (w_lvl_pp == 2'd0) begin
            r_q0 <= w_evt_dir;
          end else begin
            r_q1 <= w_evt_dir;
          end
        end
      end
    end
  end

  assign o_up            = r_stable[0];
  assign o_down          = r_stable[1];
  assign o_left          = r_stable[2];
  assign o_right         = r_stable[3];
  assign o_restart       = r_stable[4];
  assign o_dir           = r_dir;
  assign o_queue_level   = r_level;
  assign o_restart_pulse = r_restart_pulse;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed table, corner sequences and
// a randomized phase against a queue-based reference model.
module tb_input_conditioner;

  localparam int         DF = 2;
  localparam logic [1:0] RD = 2'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = 5'd0;
  logic       vsync = 1'b0;
  logic       tick = 1'b0;
  logic       o_up, o_down, o_right, o_restart, o_left, o_restart_pulse;
  logic [1:0] o_dir, o_queue_level;
  logic [4:0] lv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_conditioner #(.DEBOUNCE_FRAMES(DF), .RESET_DIR(RD)) dut (
    .clk(clk), .rst(rst),
    .i_btn_up(btn[0]), .i_btn_down(btn[1]), .i_btn_left(btn[2]),
    .i_btn_right(btn[3]), .i_btn_restart(btn[4]),
    .i_vsync(vsync), .i_tick_done(tick),
    .o_up(o_up), .o_down(o_down), .o_right(o_right), .o_restart(o_restart),
    .o_left(o_left), .o_dir(o_dir), .o_restart_pulse(o_restart_pulse),
    .o_queue_level(o_queue_level)
  );

  assign lv = {o_restart, o_right, o_left, o_down, o_up};

  typedef struct {
    logic [4:0] btn;
    logic       tick;
    logic [1:0] dir;
    logic [1:0] lvl;
  } vec_t;
  vec_t tbl[15];

  // reference model state
  logic [4:0] hist[$];
  logic [4:0] m_stab;
  logic [1:0] m_q[$];
  logic [1:0] m_dir;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One video frame: change buttons with vsync low, let them synchronise, raise vsync.
  task automatic frame(input logic [4:0] b, input logic tick_at_push);
    @(negedge clk); btn = b; vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    tick = tick_at_push;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); vsync = 1'b0; btn = 5'd0; tick = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_lv"}, {3'd0, lv}, 8'd0);
    chk({nm, "_dir"}, {6'd0, o_dir}, {6'd0, RD});
    chk({nm, "_lvl"}, {6'd0, o_queue_level}, 8'd0);
    chk({nm, "_pulse"}, {7'd0, o_restart_pulse}, 8'd0);
  endtask

  function automatic void m_reset();
    hist.delete(); m_q.delete(); m_stab = 5'd0; m_dir = RD;
  endfunction

  // A level flips once the last DF frame samples all disagree with it.
  function automatic logic m_frame(input logic [4:0] b, input logic tk);
    logic [4:0] nstab, rise;
    logic [1:0] d, r;
    logic       flip, has_evt;
    hist.push_back(b);
    nstab = m_stab;
    for (int k = 0; k < 5; k++) begin
      flip = (hist.size() >= DF);
      for (int j = 0; j < DF && flip; j++)
        if (hist[hist.size()-1-j][k] == m_stab[k]) flip = 1'b0;
      if (flip) nstab[k] = ~m_stab[k];
    end
    rise = nstab & ~m_stab;
    m_stab = nstab;
    if (rise[4]) begin
      m_q.delete(); m_dir = RD;
      return 1'b1;
    end
    if (tk && m_q.size() > 0) m_dir = m_q.pop_front();
    has_evt = 1'b1;
    if (rise[0]) d = 2'd0;
    else if (rise[1]) d = 2'd2;
    else if (rise[2]) d = 2'd3;
    else if (rise[3]) d = 2'd1;
    else begin d = 2'd0; has_evt = 1'b0; end
    if (has_evt && !m_stab[4]) begin
      r = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
      if (d != r && d != (r ^ 2'b10) && m_q.size() < 2) m_q.push_back(d);
    end
    return 1'b0;
  endfunction

  initial begin
    logic [4:0] rb;
    logic       tp, exp_pulse;

    do_reset();
    chk_reset_state("reset");

    // glitch rejection: one-frame presses never reach the stable level
    for (int i = 0; i < 3; i++) begin
      frame(5'h01, 1'b0); chk("glitch_hi", {7'd0, o_up}, 8'd0);
      frame(5'h00, 1'b0); chk("glitch_lo", {7'd0, o_up}, 8'd0);
    end
    frame(5'h01, 1'b0); chk("hold1", {7'd0, o_up}, 8'd0);
    frame(5'h01, 1'b0); chk("hold2", {7'd0, o_up}, 8'd1);
    do_reset();

    // directed table: queue fill, overflow drop, pops, reversal/same-direction drops
    tbl[0]  = '{5'h01, 1'b0, 2'd1, 2'd0};
    tbl[1]  = '{5'h01, 1'b0, 2'd1, 2'd1};
    tbl[2]  = '{5'h04, 1'b0, 2'd1, 2'd1};
    tbl[3]  = '{5'h04, 1'b0, 2'd1, 2'd2};
    tbl[4]  = '{5'h02, 1'b0, 2'd1, 2'd2};
    tbl[5]  = '{5'h02, 1'b0, 2'd1, 2'd2};
    tbl[6]  = '{5'h00, 1'b1, 2'd0, 2'd1};
    tbl[7]  = '{5'h00, 1'b1, 2'd3, 2'd0};
    tbl[8]  = '{5'h00, 1'b1, 2'd3, 2'd0};
    tbl[9]  = '{5'h08, 1'b0, 2'd3, 2'd0};
    tbl[10] = '{5'h08, 1'b0, 2'd3, 2'd0};
    tbl[11] = '{5'h04, 1'b0, 2'd3, 2'd0};
    tbl[12] = '{5'h04, 1'b0, 2'd3, 2'd0};
    tbl[13] = '{5'h00, 1'b0, 2'd3, 2'd0};
    tbl[14] = '{5'h00, 1'b0, 2'd3, 2'd0};
    for (int i = 0; i < 15; i++) begin
      frame(tbl[i].btn, 1'b0);
      if (tbl[i].tick) pulse_tick();
      chk($sformatf("tbl%0d_dir", i), {6'd0, o_dir}, {6'd0, tbl[i].dir});
      chk($sformatf("tbl%0d_lvl", i), {6'd0, o_queue_level}, {6'd0, tbl[i].lvl});
    end

    // simultaneous push and pop with queue [0,3], o_dir 3
    frame(5'h01, 1'b0); frame(5'h01, 1'b0);
    frame(5'h04, 1'b0); frame(5'h04, 1'b0);
    chk("sim_pre_lvl", {6'd0, o_queue_level}, 8'd2);
    frame(5'h02, 1'b0);
    frame(5'h02, 1'b1);
    chk("sim_dir", {6'd0, o_dir}, 8'd0);
    chk("sim_lvl", {6'd0, o_queue_level}, 8'd2);
    pulse_tick(); chk("sim_pop1", {6'd0, o_dir}, 8'd3);
    pulse_tick(); chk("sim_pop2", {6'd0, o_dir}, 8'd2);
    chk("sim_empty", {6'd0, o_queue_level}, 8'd0);
    frame(5'h00, 1'b0); frame(5'h00, 1'b0);

    // restart: queue [0], o_dir 3
    frame(5'h04, 1'b0); frame(5'h04, 1'b0);
    pulse_tick();
    frame(5'h01, 1'b0); frame(5'h01, 1'b0);
    frame(5'h00, 1'b0); frame(5'h00, 1'b0);
    chk("rs_pre_dir", {6'd0, o_dir}, 8'd3);
    chk("rs_pre_lvl", {6'd0, o_queue_level}, 8'd1);
    frame(5'h10, 1'b0);
    chk("rs_early_pulse", {7'd0, o_restart_pulse}, 8'd0);
    frame(5'h10, 1'b0);
    chk("rs_pulse", {7'd0, o_restart_pulse}, 8'd1);
    chk("rs_dir", {6'd0, o_dir}, {6'd0, RD});
    chk("rs_lvl", {6'd0, o_queue_level}, 8'd0);
    @(negedge clk);
    chk("rs_pulse_end", {7'd0, o_restart_pulse}, 8'd0);
    frame(5'h11, 1'b0); frame(5'h11, 1'b0);
    chk("rs_held_up", {6'd0, o_up, o_restart}, 8'd3);
    chk("rs_held_lvl", {6'd0, o_queue_level}, 8'd0);
    frame(5'h00, 1'b0); frame(5'h00, 1'b0);

    // reset with a full queue and a counter mid-count
    frame(5'h01, 1'b0); frame(5'h01, 1'b0);
    frame(5'h04, 1'b0); frame(5'h04, 1'b0);
    chk("mid_full", {6'd0, o_queue_level}, 8'd2);
    frame(5'h02, 1'b0);
    do_reset();
    chk_reset_state("mid_reset");
    frame(5'h02, 1'b0);
    chk("mid_fresh1", {7'd0, o_down}, 8'd0);
    frame(5'h02, 1'b0);
    chk("mid_fresh2", {7'd0, o_down}, 8'd1);
    chk("mid_push", {6'd0, o_queue_level}, 8'd1);

    // randomized phase against the reference model
    do_reset();
    m_reset();
    rb = 5'd0;
    for (int f = 0; f < 200; f++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 2) == 0) rb[k] = ~rb[k];
      if ($urandom_range(0, 9) == 0) rb[4] = ~rb[4];
      tp = ($urandom_range(0, 3) == 0);
      frame(rb, tp);
      exp_pulse = m_frame(rb, tp);
      chk($sformatf("rnd%0d_lv", f), {3'd0, lv}, {3'd0, m_stab});
      chk($sformatf("rnd%0d_pulse", f), {7'd0, o_restart_pulse}, {7'd0, exp_pulse});
      chk($sformatf("rnd%0d_dir", f), {6'd0, o_dir}, {6'd0, m_dir});
      chk($sformatf("rnd%0d_lvl", f), {6'd0, o_queue_level}, 8'(m_q.size()));
      if ($urandom_range(0, 2) == 0) begin
        pulse_tick();
        if (m_q.size() > 0) m_dir = m_q.pop_front();
        chk($sformatf("rnd%0d_tdir", f), {6'd0, o_dir}, {6'd0, m_dir});
        chk($sformatf("rnd%0d_tlvl", f), {6'd0, o_queue_level}, 8'(m_q.size()));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
